// File: rtl/cpu_pipe_pkg.sv
// +--------------------------------------------------------------------+
// | cpu_pipe_pkg : shared types and constants for pipeline registers    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package cpu_pipe_pkg;

  localparam int PIPE_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    HALF  = 2'b01,
    FULL  = 2'b11
  } skid_state_t;

endpackage

`default_nettype wire

// File: rtl/pipe_skid_slot.sv
// +--------------------------------------------------------------------+
// | pipe_skid_slot : one payload register with load enable, async clear |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module pipe_skid_slot
  import cpu_pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= d;
    end
  end

  assign q = data_q;

endmodule

`default_nettype wire

// File: rtl/pipe_skid_reg.sv
// +--------------------------------------------------------------------+
// | pipe_skid_reg : two-entry skid buffer with registered in_ready and  |
// | synchronous flush. Optional PIPE_SKID_STALL_CNT_EN adds stall_cnt.  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module pipe_skid_reg
  import cpu_pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_SKID_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  skid_state_t      state_q;
  skid_state_t      state_d;
  logic             main_load;
  logic [WIDTH-1:0] main_d;
  logic             skid_load;
  logic [WIDTH-1:0] skid_q;
  logic             accept;
  logic             consume;

  // Handshake flags derive purely from state, keeping out_ready off the in_ready path.
  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (state_q != FULL);
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    main_load = 1'b0;
    main_d    = in_data;
    skid_load = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d   = HALF;
          main_load = 1'b1;
        end
      end
      HALF: begin
        if (accept && consume) begin
          main_load = 1'b1;
        end else if (accept) begin
          state_d   = FULL;
          skid_load = 1'b1;
        end else if (consume) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (consume) begin
          state_d   = HALF;
          main_load = 1'b1;
          main_d    = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush wins over any same-cycle handshake; stale payload is harmless once invalid.
    if (flush) begin
      state_d   = EMPTY;
      main_load = 1'b0;
      skid_load = 1'b0;
    end
  end

  pipe_skid_slot #(.WIDTH(WIDTH)) u_main_slot (
    .clk  (clk),
    .clrn (clrn),
    .load (main_load),
    .d    (main_d),
    .q    (out_data)
  );

  pipe_skid_slot #(.WIDTH(WIDTH)) u_skid_slot (
    .clk  (clk),
    .clrn (clrn),
    .load (skid_load),
    .d    (in_data),
    .q    (skid_q)
  );

`ifdef PIPE_SKID_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      stall_cnt_q <= 16'd0;
    end else if (out_valid && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

`default_nettype wire
